// File: rtl/stop_it_pkg.sv
// Shared types and default timing for the Stop-It game controller.
package stop_it_pkg;

  typedef enum logic [2:0] {
    WAITING_TO_START = 3'd0,
    STARTING         = 3'd1,
    DECREMENTING     = 3'd2,
    WRONG            = 3'd3,
    CORRECT          = 3'd4,
    WON              = 3'd5
  } state_t;

  localparam int DEFAULT_START_CYCLES  = 8;
  localparam int DEFAULT_RESULT_CYCLES = 16;
  localparam int DEFAULT_CNT_W         = 7;

  localparam logic [3:0] DIGITS_OFF   = 4'b0000;
  localparam logic [3:0] DIGITS_LEFT  = 4'b1100;
  localparam logic [3:0] DIGITS_ALL   = 4'b1111;
  localparam logic [3:0] DIGITS_RIGHT = 4'b0011;

  // Counter width able to hold the longer of the two dwells.
  function automatic int dwell_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Saturating dwell counter: cleared on state entry, flags the last cycle of a dwell.
module dwell_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_inc;

  assign count_inc = count_q + W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_q != '1) begin
      count_q <= count_inc;
    end
  end

  // At saturation count_inc is zero, which never equals a nonzero limit.
  assign done = (count_inc == limit);

endmodule

// File: rtl/stop_it_ctrl.sv
// Stop-It game controller FSM. Optional WON-state LED blink via STOP_IT_BLINK_EN.
module stop_it_ctrl
  import stop_it_pkg::*;
#(
  parameter int START_CYCLES  = DEFAULT_START_CYCLES,
  parameter int RESULT_CYCLES = DEFAULT_RESULT_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic             clk_4_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic             stop_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] rand_i,
  input  logic [CNT_W-1:0] game_count_i,
  input  logic [15:0]      leds_i,
  output logic             lfsr_next_o,
  output logic             gc_clr_o,
  output logic             gc_en_o,
  output logic             tc_clr_o,
  output logic             tc_en_o,
  output logic             ls_load_o,
  output logic             ls_shift_o,
  output logic             ls_off_o,
  output logic [CNT_W-1:0] target_o,
  output logic [3:0]       digit_en_o,
  output state_t           state_o
);

  localparam int DWELL_W = dwell_width(START_CYCLES, RESULT_CYCLES);

  state_t             state_q;
  state_t             state_d;
  logic               entry_q;
  logic               lfsr_pend_q;
  logic [CNT_W-1:0]   target_q;
  logic               dwell_clear;
  logic               dwell_done;
  logic [DWELL_W-1:0] dwell_limit;
  logic               blink;

  assign dwell_clear = (state_d != state_q);

  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WAITING_TO_START;
    end else begin
      state_q <= state_d;
    end
  end

  // The LFSR advances on the pulse edge; its new value is captured one edge later.
  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q     <= 1'b0;
      lfsr_pend_q <= 1'b0;
      target_q    <= '0;
    end else begin
      entry_q     <= dwell_clear;
      lfsr_pend_q <= lfsr_next_o;
      if (lfsr_pend_q) begin
        target_q <= rand_i;
      end
    end
  end

  always_comb begin
    dwell_limit = DWELL_W'(RESULT_CYCLES);
    if (state_q == STARTING) begin
      dwell_limit = DWELL_W'(START_CYCLES);
    end
  end

  dwell_timer #(
    .W(DWELL_W)
  ) u_dwell (
    .clk  (clk_4_i),
    .rst  (rst_i),
    .clear(dwell_clear),
    .limit(dwell_limit),
    .done (dwell_done)
  );

`ifdef STOP_IT_BLINK_EN
  logic [1:0] blink_q;

  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      blink_q <= 2'd0;
    end else if (dwell_clear) begin
      blink_q <= 2'd0;
    end else begin
      blink_q <= blink_q + 2'd1;
    end
  end

  assign blink = blink_q[1];
`else
  assign blink = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAITING_TO_START: if (go_i) state_d = STARTING;
      STARTING:         if (dwell_done) state_d = DECREMENTING;
      DECREMENTING: begin
        // A stop in the same cycle as the count reaching zero wins.
        if (stop_i) begin
          state_d = (game_count_i == target_q) ? CORRECT : WRONG;
        end else if (game_count_i == '0) begin
          state_d = WRONG;
        end
      end
      CORRECT: begin
        if (dwell_done) begin
          state_d = (leds_i == 16'hFFFF) ? WON : STARTING;
        end
      end
      WRONG:   if (dwell_done) state_d = STARTING;
      WON:     if (go_i) state_d = WAITING_TO_START;
      default: state_d = WAITING_TO_START;
    endcase
  end

  always_comb begin
    lfsr_next_o = 1'b0;
    gc_clr_o    = 1'b0;
    gc_en_o     = 1'b0;
    tc_clr_o    = 1'b0;
    tc_en_o     = 1'b0;
    ls_load_o   = 1'b0;
    ls_shift_o  = 1'b0;
    ls_off_o    = 1'b0;
    digit_en_o  = DIGITS_OFF;
    case (state_q)
      WAITING_TO_START: begin
        ls_load_o = load_i & ~rst_i;
        gc_clr_o  = 1'b1;
        tc_clr_o  = 1'b1;
      end
      STARTING: begin
        lfsr_next_o = entry_q;
        gc_clr_o    = 1'b1;
        tc_clr_o    = 1'b1;
        digit_en_o  = DIGITS_LEFT;
      end
      DECREMENTING: begin
        gc_en_o    = 1'b1;
        tc_en_o    = 1'b1;
        digit_en_o = DIGITS_ALL;
      end
      CORRECT: begin
        ls_shift_o = entry_q;
        digit_en_o = DIGITS_ALL;
      end
      WRONG: begin
        ls_off_o   = 1'b1;
        digit_en_o = DIGITS_ALL;
      end
      WON: begin
        ls_off_o   = blink;
        digit_en_o = DIGITS_RIGHT;
      end
      default: begin
        gc_clr_o = 1'b1;
        tc_clr_o = 1'b1;
      end
    endcase
  end

  assign target_o = target_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_stop_it_ctrl.sv
// Randomized scoreboard bench for stop_it_ctrl against a cycle-level game model.
module tb_stop_it_ctrl;
  import stop_it_pkg::*;

  localparam int START  = 8;
  localparam int RESULT = 16;

  logic        clk = 1'b0;
  logic        rst_i, go_i, stop_i, load_i;
  logic [6:0]  rand_i, game_count_i;
  logic [15:0] leds_i;
  logic        lfsr_next_o, gc_clr_o, gc_en_o, tc_clr_o, tc_en_o;
  logic        ls_load_o, ls_shift_o, ls_off_o;
  logic [6:0]  target_o;
  logic [3:0]  digit_en_o;
  state_t      state_o;

  always #5 clk = ~clk;

  stop_it_ctrl dut (
    .clk_4_i     (clk),
    .rst_i       (rst_i),
    .go_i        (go_i),
    .stop_i      (stop_i),
    .load_i      (load_i),
    .rand_i      (rand_i),
    .game_count_i(game_count_i),
    .leds_i      (leds_i),
    .lfsr_next_o (lfsr_next_o),
    .gc_clr_o    (gc_clr_o),
    .gc_en_o     (gc_en_o),
    .tc_clr_o    (tc_clr_o),
    .tc_en_o     (tc_en_o),
    .ls_load_o   (ls_load_o),
    .ls_shift_o  (ls_shift_o),
    .ls_off_o    (ls_off_o),
    .target_o    (target_o),
    .digit_en_o  (digit_en_o),
    .state_o     (state_o)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] tgt;
    logic [3:0] dig;
    logic [7:0] strobes;  // lfsr, gc_clr, gc_en, tc_clr, tc_en, load, shift, off
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Game model: phase, cycles spent in it, and the latched target.
  state_t     m_st;
  int         m_t;
  logic [6:0] m_tgt;

  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (state_o == state_t'(e.st)) passed++;
      else $display("FAIL state @%0t: got %0d want %0d", $time, state_o, e.st);
      checks++;
      if (target_o == e.tgt) passed++;
      else $display("FAIL target @%0t: got %h want %h", $time, target_o, e.tgt);
      checks++;
      if ({digit_en_o, lfsr_next_o, gc_clr_o, gc_en_o, tc_clr_o, tc_en_o,
           ls_load_o, ls_shift_o, ls_off_o} == {e.dig, e.strobes}) passed++;
      else $display("FAIL outputs @%0t (state %0d t): got dig=%b str=%b want dig=%b str=%b",
                    $time, e.st, digit_en_o,
                    {lfsr_next_o, gc_clr_o, gc_en_o, tc_clr_o, tc_en_o, ls_load_o, ls_shift_o, ls_off_o},
                    e.dig, e.strobes);
    end
  end

  function automatic obs_t expect_now();
    obs_t o;
    logic lf, gcc, gce, tcc, tce, ld, sh, off;
    o = '0;
    {lf, gcc, gce, tcc, tce, ld, sh, off} = 8'b0;
    o.st  = m_st;
    o.tgt = m_tgt;
    case (m_st)
      WAITING_TO_START: begin ld = load_i & ~rst_i; gcc = 1; tcc = 1; o.dig = 4'b0000; end
      STARTING:         begin lf = (m_t == 0); gcc = 1; tcc = 1; o.dig = 4'b1100; end
      DECREMENTING:     begin gce = 1; tce = 1; o.dig = 4'b1111; end
      CORRECT:          begin sh = (m_t == 0); o.dig = 4'b1111; end
      WRONG:            begin off = 1; o.dig = 4'b1111; end
      WON: begin
        o.dig = 4'b0011;
`ifdef STOP_IT_BLINK_EN
        off = ((m_t / 2) % 2) == 1;
`else
        off = 1'b0;
`endif
      end
      default: ;
    endcase
    o.strobes = {lf, gcc, gce, tcc, tce, ld, sh, off};
    return o;
  endfunction

  task automatic model_step();
    state_t nx;
    nx = m_st;
    case (m_st)
      WAITING_TO_START: if (go_i) nx = STARTING;
      STARTING: begin
        if (m_t == 1) m_tgt = rand_i;
        if (m_t == START - 1) nx = DECREMENTING;
      end
      DECREMENTING: begin
        if (stop_i) nx = (game_count_i == m_tgt) ? CORRECT : WRONG;
        else if (game_count_i == 0) nx = WRONG;
      end
      CORRECT: if (m_t == RESULT - 1) nx = (leds_i == 16'hFFFF) ? WON : STARTING;
      WRONG:   if (m_t == RESULT - 1) nx = STARTING;
      WON:     if (go_i) nx = WAITING_TO_START;
      default: nx = WAITING_TO_START;
    endcase
    if (nx != m_st) m_t = 0;
    else m_t++;
    m_st = nx;
  endtask

  initial begin
    obs_t       e;
    logic [6:0] forced[$];
    logic [6:0] gc;
    int         rnd, mode;
    bit         did_rst, lfsr_prev;

    forced = '{7'h2A, 7'h2A, 7'h00, 7'h05};
    rst_i = 1; go_i = 0; stop_i = 0; load_i = 0;
    rand_i = 7'h11; game_count_i = 0; leds_i = 0;
    m_st = WAITING_TO_START; m_t = 0; m_tgt = 0;
    rnd = -1; mode = 0; gc = 0; did_rst = 0; lfsr_prev = 0;
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (lfsr_prev) rand_i = (forced.size() > 0) ? forced.pop_front() : 7'($urandom_range(0, 127));

      rst_i = (cyc < 2);
      if (!did_rst && rnd == 4 && m_st == DECREMENTING && m_t == 3) begin
        rst_i = 1; did_rst = 1;
      end else if (rnd >= 5 && $urandom_range(0, 399) == 0) begin
        rst_i = 1;
      end
      if (rst_i) begin
        m_st = WAITING_TO_START; m_t = 0; m_tgt = 0;
      end

      load_i = 1'($urandom_range(0, 1));
      case (m_st)
        WAITING_TO_START: go_i = ($urandom_range(0, 3) == 0);
        WON:              go_i = ($urandom_range(0, 4) == 0);
        default:          go_i = ($urandom_range(0, 9) == 0);
      endcase
      if (rnd == 0)      leds_i = 16'h00FF;
      else if (rnd == 1) leds_i = 16'hFFFF;
      else               leds_i = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);

      if (m_st == DECREMENTING) begin
        if (m_t == 0) begin
          rnd++;
          mode = (rnd < 2) ? 0 : (rnd < 4) ? 1 : int'($urandom_range(0, 3));
          gc = (m_tgt > 7'd121) ? 7'd127 : m_tgt + 7'($urandom_range(0, 6));
        end else begin
          gc = (gc == 0) ? 7'd0 : gc - 7'd1;
        end
        game_count_i = gc;
        case (mode)
          0:       stop_i = (gc == m_tgt);
          1:       stop_i = (gc == 0);
          2:       stop_i = 0;
          default: stop_i = ($urandom_range(0, 7) == 0);
        endcase
      end else begin
        game_count_i = 7'($urandom);
        stop_i = ($urandom_range(0, 9) == 0);
      end

      e = expect_now();
      exp_q.push_back(e);
      lfsr_prev = e.strobes[7];
      @(posedge clk);
      if (!rst_i) model_step();
      #1;
    end
    rst_i = 0;
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
